// File: rtl/volt_cal_seq.sv
// volt_cal_seq: snapshots CH_NUM signed AD samples and converts each, one channel at a time,
// into an ASCII sign and a packed-BCD voltage through one shared multiplier and double dabble.
module volt_cal_seq #(
    parameter int CH_NUM = 8,
    parameter int DATA_W = 16,
    parameter int FS_SCALE = 50000,
    parameter int BCD_DIGITS = 5,
    localparam int VOL_W = $clog2(FS_SCALE + 1),
    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_valid,
    input  logic [CH_NUM*DATA_W-1:0]   ad_data,
    output logic                       busy,
    output logic                       out_valid,
    output logic [CH_W-1:0]            out_ch,
    output logic [7:0]                 out_sign,
    output logic [4*BCD_DIGITS-1:0]    out_bcd,
    output logic                       frame_done,
    output logic                       overrun
);
    localparam int PW = DATA_W + VOL_W;
    localparam int CW = $clog2(VOL_W + 1);
    localparam int BW = 4 * BCD_DIGITS;
    localparam logic [VOL_W-1:0] FS_V = VOL_W'(FS_SCALE);
    localparam logic [2:0] S_IDLE = 3'd0, S_ABS = 3'd1, S_MUL = 3'd2, S_SCALE = 3'd3,
                           S_BCD = 3'd4, S_OUT = 3'd5, S_DONE = 3'd6;

    if (FS_SCALE >= 10 ** BCD_DIGITS) begin : g_bcd_too_narrow
        $error("volt_cal_seq: FS_SCALE does not fit in BCD_DIGITS digits");
    end

    logic [2:0]               state;
    logic [CH_NUM*DATA_W-1:0] snap;
    logic [CH_W-1:0]          ch;
    logic [DATA_W-1:0]        s, mag;
    logic [7:0]               sgn;
    logic [PW-1:0]            prod;
    logic [VOL_W-1:0]         bin;
    logic [BW-1:0]            bcd, adj;
    logic [CW-1:0]            cnt;

    always_comb begin
        s = snap[ch*DATA_W +: DATA_W];
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Status pulses are registered from the state, so they trail the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            snap <= '0;
            ch <= '0;
            mag <= '0;
            sgn <= '0;
            prod <= '0;
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            busy <= 1'b0;
            out_valid <= 1'b0;
            out_ch <= '0;
            out_sign <= '0;
            out_bcd <= '0;
            frame_done <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy <= state != S_IDLE;
            overrun <= frame_valid && state != S_IDLE;
            out_valid <= state == S_OUT;
            frame_done <= state == S_DONE;
            case (state)
                S_IDLE: if (frame_valid) begin
                    snap <= ad_data;
                    ch <= '0;
                    state <= S_ABS;
                end
                S_ABS: begin
                    mag <= s[DATA_W-1] ? ~s + 1'b1 : s;
                    sgn <= s[DATA_W-1] ? 8'd45 : 8'd43;
                    state <= S_MUL;
                end
                S_MUL: begin
                    prod <= PW'(mag) * PW'(FS_V);
                    state <= S_SCALE;
                end
                S_SCALE: begin
                    bin <= prod[DATA_W-1 +: VOL_W];
                    bcd <= '0;
                    cnt <= '0;
                    state <= S_BCD;
                end
                S_BCD: begin
                    bcd <= {adj[BW-2:0], bin[VOL_W-1]};
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    state <= (cnt == CW'(VOL_W - 1)) ? S_OUT : S_BCD;
                end
                S_OUT: begin
                    out_ch <= ch;
                    out_sign <= sgn;
                    out_bcd <= bcd;
                    ch <= (ch == CH_W'(CH_NUM - 1)) ? ch : ch + 1'b1;
                    state <= (ch == CH_W'(CH_NUM - 1)) ? S_DONE : S_ABS;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_volt_cal_seq.sv
// tb_volt_cal_seq: directed checks of volt_cal_seq at default parameters and at
// CH_NUM=2, DATA_W=12, FS_SCALE=25000.
module tb_volt_cal_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_valid;
    logic [127:0] ad_data;
    logic        busy, out_valid, frame_done, overrun;
    logic [2:0]  out_ch;
    logic [7:0]  out_sign;
    logic [19:0] out_bcd;

    logic        fv2;
    logic [23:0] ad2;
    logic        busy2, ov2, fd2, orun2;
    logic [0:0]  ch2;
    logic [7:0]  sgn2;
    logic [19:0] bcd2;

    int checks = 0;
    int errors = 0;

    logic [15:0] dat  [3][8];
    logic [19:0] ebcd [2][8];
    logic [7:0]  esgn [2][8];
    logic [2:0]  e_ch;
    logic [7:0]  e_sgn;
    logic [19:0] e_bcd;

    always #10 clk = ~clk;

    volt_cal_seq dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .ad_data(ad_data),
        .busy(busy), .out_valid(out_valid), .out_ch(out_ch), .out_sign(out_sign),
        .out_bcd(out_bcd), .frame_done(frame_done), .overrun(overrun)
    );

    volt_cal_seq #(.CH_NUM(2), .DATA_W(12), .FS_SCALE(25000)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_valid(fv2), .ad_data(ad2),
        .busy(busy2), .out_valid(ov2), .out_ch(ch2), .out_sign(sgn2),
        .out_bcd(bcd2), .frame_done(fd2), .overrun(orun2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sign", out_sign, 0);
        chk("rst_out_bcd", out_bcd, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    task automatic drive(input int f);
        for (int k = 0; k < 8; k++) ad_data[k*16 +: 16] = dat[f][k];
        frame_valid = 1'b1;
    endtask

    task automatic start(input int f);
        drive(f);
        tick();
        frame_valid = 1'b0;
        chk("busy_t0", busy, 0);
        chk("overrun_t0", overrun, 0);
    endtask

    // t counts cycles after the capture edge; ovr_t injects a frame_valid while busy.
    task automatic check_frame(input int f, input int last_t, input int ovr_t, input int next_f);
        for (int t = 1; t <= last_t; t++) begin
            logic ov;
            tick();
            ov = (t % 20 == 0) && t >= 20 && t <= 160;
            if (ov) begin
                e_ch = 3'(t / 20 - 1);
                e_sgn = esgn[f][t/20-1];
                e_bcd = ebcd[f][t/20-1];
            end
            chk("out_valid", out_valid, ov);
            chk("frame_done", frame_done, t == 161);
            chk("busy", busy, 1);
            chk("overrun", overrun, ovr_t > 0 && t == ovr_t + 1);
            chk("out_ch", out_ch, e_ch);
            chk("out_sign", out_sign, e_sgn);
            chk("out_bcd", out_bcd, e_bcd);
            if (ovr_t > 0 && t == ovr_t) drive(2);
            if (ovr_t > 0 && t == ovr_t + 1) frame_valid = 1'b0;
            if (t == 161 && next_f >= 0) drive(next_f);
        end
    endtask

    initial begin
        dat[0] = '{16'h4000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hC000, 16'h0001, 16'h8001};
        ebcd[0] = '{20'h25000, 20'h50000, 20'h00001, 20'h49998, 20'h00000, 20'h25000, 20'h00001, 20'h49998};
        esgn[0] = '{8'd43, 8'd45, 8'd45, 8'd43, 8'd43, 8'd45, 8'd43, 8'd45};
        dat[1] = '{16'h2000, 16'hE000, 16'h0100, 16'h1000, 16'hFF00, 16'h0800, 16'h0002, 16'hF000};
        ebcd[1] = '{20'h12500, 20'h12500, 20'h00390, 20'h06250, 20'h00390, 20'h03125, 20'h00003, 20'h06250};
        esgn[1] = '{8'd43, 8'd45, 8'd43, 8'd43, 8'd45, 8'd43, 8'd43, 8'd45};
        for (int k = 0; k < 8; k++) dat[2][k] = 16'h1234;

        rst_n = 1'b0;
        frame_valid = 1'b0;
        ad_data = '0;
        fv2 = 1'b0;
        ad2 = '0;
        e_ch = '0;
        e_sgn = '0;
        e_bcd = '0;
        repeat (3) tick();
        chk_zero();
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            chk_zero();
        end

        start(0);
        check_frame(0, 161, 50, 1);
        tick();
        frame_valid = 1'b0;
        chk("b2b_busy", busy, 0);
        chk("b2b_overrun", overrun, 0);

        check_frame(1, 70, 0, -1);
        rst_n = 1'b0;
        #1;
        chk_zero();
        e_ch = '0;
        e_sgn = '0;
        e_bcd = '0;
        repeat (2) begin
            tick();
            chk_zero();
        end
        rst_n = 1'b1;
        repeat (200) begin
            tick();
            chk_zero();
        end

        start(0);
        check_frame(0, 161, 0, -1);
        tick();
        chk("end_busy", busy, 0);
        chk("end_out_valid", out_valid, 0);
        chk("end_frame_done", frame_done, 0);

        ad2 = {12'h400, 12'h800};
        fv2 = 1'b1;
        tick();
        fv2 = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            chk("p2_out_valid", ov2, t == 19 || t == 38);
            chk("p2_frame_done", fd2, t == 39);
            chk("p2_busy", busy2, t <= 39);
            chk("p2_overrun", orun2, 0);
            if (t == 19) begin
                chk("p2_ch0", ch2, 0);
                chk("p2_sign0", sgn2, 8'd45);
                chk("p2_bcd0", bcd2, 20'h25000);
            end
            if (t == 38) begin
                chk("p2_ch1", ch2, 1);
                chk("p2_sign1", sgn2, 8'd43);
                chk("p2_bcd1", bcd2, 20'h12500);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
